vlc_frame_tx: RTL and testbench
===============================

# vlc_frame_tx

Transmit frame sequencer for the VLC link. On a frame request it triggers the Schmidl-Cox preamble generator and forwards its samples, optionally inserts a guard interval, then streams a fixed-length payload from an upstream valid/ready source. It produces one continuous registered sample stream toward the DAC driver. It sits between the MAC/payload buffer and the DAC path, driving the preamble generator's start input and consuming its data and end outputs.

## Interface
- WIDTH, 10, sample width for preamble, payload and output.
- PRE_LEN, 128, preamble samples; equals twice the preamble half length.
- PRE_DELAY, 2, cycles from `o_pre_start` high to the first valid preamble sample on `i_pre_data`.
- PAYLOAD_LEN, 256, payload samples per frame, from 1 to 65535.
- GUARD_LEN, 16, guard samples, from 1 to 255; used only with the guard macro.
- IDLE_VALUE, 0, value driven on `o_data` outside sample slots and on payload underrun.
- clk  in  1  clock; the block uses one clock only.
- reset  in  1  synchronous, active-high reset.
- i_start  in  1  frame request; sampled only in IDLE.
- o_busy  out  1  high from the cycle after an accepted `i_start` until `o_done`.
- o_done  out  1  one-cycle pulse after the last frame sample.
- o_pre_start  out  1  one-cycle start pulse to the preamble generator.
- i_pre_data  in  WIDTH  preamble sample from the generator.
- i_pre_end  in  1  end pulse from the generator.
- i_pl_data  in  WIDTH  payload sample.
- i_pl_valid  in  1  payload sample valid.
- o_pl_ready  out  1  payload ready; a transfer occurs when `i_pl_valid` and `o_pl_ready` are both high.
- o_data  out  WIDTH  registered output sample.
- o_valid  out  1  high on every frame sample slot.
- o_underrun  out  1  sticky; payload slot had no valid input.
- o_pre_err  out  1  sticky; `i_pre_end` did not arrive at the expected cycle.

## Operation
- States: IDLE, START, PRE_WAIT, PREAMBLE, GUARD, PAYLOAD, DONE.
- IDLE:
  - On `i_start`, go to START.
  - Clear `o_underrun` and `o_pre_err`.
- START: assert `o_pre_start` for one cycle, then go to PRE_WAIT.
- PRE_WAIT: wait PRE_DELAY-1 cycles, then go to PREAMBLE. With PRE_DELAY=1, go directly to PREAMBLE.
- PREAMBLE:
  - Capture `i_pre_data` for PRE_LEN cycles into `o_data` with `o_valid` set.
  - Then go to GUARD if the guard macro is defined, otherwise to PAYLOAD.
- GUARD: output GUARD_LEN samples of IDLE_VALUE with `o_valid` set, then go to PAYLOAD.
- PAYLOAD:
  - `o_pl_ready` is high for exactly PAYLOAD_LEN cycles; every cycle is one sample slot.
  - If `i_pl_valid` is high, output `i_pl_data`.
  - If `i_pl_valid` is low, output IDLE_VALUE, set `o_underrun`, and still consume the slot. The frame length never stretches.
- DONE: pulse `o_done` for one cycle, drop `o_busy`, return to IDLE.
- Preamble end check:
  - `i_pre_end` is expected exactly PRE_LEN+1 cycles after the `o_pre_start` cycle.
  - If it is high at any other cycle while busy, or low at the expected cycle, set `o_pre_err`.
  - An error does not abort the frame.
- `i_start` outside IDLE is ignored; requests are not queued.
- Counters:
  - Sample counter is 16 bits and terminates at N-1.
  - No wrap-around occurs within a frame.
- Outside sample slots: `o_data` = IDLE_VALUE and `o_valid` = 0.

## Timing
- Reset values:
  - `o_data` = IDLE_VALUE.
  - `o_busy`, `o_done`, `o_pre_start`, `o_pl_ready`, `o_valid`, `o_underrun`, `o_pre_err` = 0.
  - State = IDLE; counters = 0.
- Reset mid-frame:
  - Returns to IDLE on the next edge with no `o_done` pulse.
  - The preamble generator shares the same reset.
- Cycle sequence, with `i_start` high at cycle T:
  - T+1: `o_pre_start` high; `o_busy` high from T+1.
  - T+1+PRE_DELAY: first preamble capture.
  - T+2+PRE_DELAY: first `o_valid`.
- Latency: input to `o_data` is one cycle. A payload transfer at cycle k appears at k+1.
- Frame length: `o_valid` is high for PRE_LEN + PAYLOAD_LEN contiguous cycles (+GUARD_LEN when the guard is compiled in), with no gaps.
- `o_done` pulses in the cycle after the last `o_valid`.
- Back-to-back: `i_start` held high begins the next frame two cycles after `o_done`.

## Configuration
- `VLC_FRAME_TX_GUARD_EN` defined:
  - GUARD state is present.
  - GUARD_LEN samples of IDLE_VALUE are inserted between preamble and payload.
- Undefined:
  - GUARD state and its logic are absent.
  - PAYLOAD immediately follows PREAMBLE; GUARD_LEN is ignored.

## Test plan
- Defaults, guard off, payload always valid with ramp 0..255, `i_start` at cycle 10:
  - `o_pre_start` at cycle 11.
  - 384 contiguous `o_valid` cycles: 128 preamble samples, then 0..255.
  - `o_done` one cycle after the last sample; both error flags 0.
- Guard on:
  - Exactly 16 samples of IDLE_VALUE between preamble sample 127 and payload sample 0.
  - Total 400 valid cycles.
- `i_pl_valid` low for payload slots 5–7:
  - Those slots output 0.
  - `o_underrun` set and held until the next accepted `i_start`.
  - Frame length unchanged.
- `i_pre_end` delayed by one cycle → `o_pre_err` = 1 and the frame still completes.
- `i_start` pulsed mid-frame → ignored, no second `o_pre_start`.
- Reset during PAYLOAD → next cycle: all outputs at reset values, no `o_done`.

Source files
------------

// File: rtl/vlc_frame_tx.sv
// vlc_frame_tx: VLC transmit frame sequencer (preamble, optional guard via VLC_FRAME_TX_GUARD_EN, payload)
module vlc_frame_tx #(
    parameter int WIDTH       = 10,
    parameter int PRE_LEN     = 128,
    parameter int PRE_DELAY   = 2,
    parameter int PAYLOAD_LEN = 256,
    parameter int GUARD_LEN   = 16,
    parameter int IDLE_VALUE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pre_start,
    input  logic [WIDTH-1:0] i_pre_data,
    input  logic             i_pre_end,
    input  logic [WIDTH-1:0] i_pl_data,
    input  logic             i_pl_valid,
    output logic             o_pl_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_underrun,
    output logic             o_pre_err
);
    localparam logic [WIDTH-1:0] IDLE_D = WIDTH'(IDLE_VALUE);
    if (PAYLOAD_LEN < 1 || PAYLOAD_LEN > 65535 || PRE_DELAY < 1 || GUARD_LEN < 1 || GUARD_LEN > 255) begin : g_bad_param
        $error("vlc_frame_tx: parameter out of range");
    end
    typedef enum logic [2:0] {
        IDLE,
        START,
        PRE_WAIT,
        PREAMBLE,
`ifdef VLC_FRAME_TX_GUARD_EN
        GUARD,
`endif
        PAYLOAD,
        DONE
    } state_t;
    state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d, pre_t_q, pre_t_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic valid_q, valid_d, underrun_q, underrun_d, pre_err_q, pre_err_d, done_q, done_d;
    logic accept, busy;
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (i_start && !done_q) state_d = START;
            START:    state_d = PRE_DELAY > 1 ? PRE_WAIT : PREAMBLE;
            PRE_WAIT: if (cnt_q == 16'(PRE_DELAY - 2)) state_d = PREAMBLE;
`ifdef VLC_FRAME_TX_GUARD_EN
            PREAMBLE: if (cnt_q == 16'(PRE_LEN - 1)) state_d = GUARD;
            GUARD:    if (cnt_q == 16'(GUARD_LEN - 1)) state_d = PAYLOAD;
`else
            PREAMBLE: if (cnt_q == 16'(PRE_LEN - 1)) state_d = PAYLOAD;
`endif
            PAYLOAD:  if (cnt_q == 16'(PAYLOAD_LEN - 1)) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end
    // o_done is registered so it lands one cycle after the last registered sample
    always_comb begin
        accept     = state_q == IDLE && i_start && !done_q;
        busy       = state_q != IDLE;
        cnt_d      = (state_d != state_q || state_q == IDLE) ? 16'd0 : cnt_q + 16'd1;
        pre_t_d    = !busy ? 16'd0 : (&pre_t_q ? pre_t_q : pre_t_q + 16'd1);
        pre_err_d  = accept ? 1'b0 : pre_err_q | (busy && (i_pre_end != (pre_t_q == 16'(PRE_LEN + 1))));
        underrun_d = accept ? 1'b0 : underrun_q | (state_q == PAYLOAD && !i_pl_valid);
`ifdef VLC_FRAME_TX_GUARD_EN
        valid_d    = state_q == PREAMBLE || state_q == GUARD || state_q == PAYLOAD;
`else
        valid_d    = state_q == PREAMBLE || state_q == PAYLOAD;
`endif
        data_d     = state_q == PREAMBLE ? i_pre_data :
                     (state_q == PAYLOAD && i_pl_valid) ? i_pl_data : IDLE_D;
        done_d     = state_q == DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pre_t_q    <= '0;
            data_q     <= IDLE_D;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
            pre_err_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pre_t_q    <= pre_t_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
            pre_err_q  <= pre_err_d;
            done_q     <= done_d;
        end
    end
    assign o_busy      = busy;
    assign o_done      = done_q;
    assign o_pre_start = state_q == START;
    assign o_pl_ready  = state_q == PAYLOAD;
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_underrun  = underrun_q;
    assign o_pre_err   = pre_err_q;
endmodule

// File: tb/tb_vlc_frame_tx.sv
// tb_vlc_frame_tx: scoreboard bench for vlc_frame_tx with a preamble generator model
module tb_vlc_frame_tx;
    localparam int W  = 10;
    localparam int PL = 128;
    localparam int PD = 2;
    localparam int NL = 256;
`ifdef VLC_FRAME_TX_GUARD_EN
    localparam int GN = 16;
`else
    localparam int GN = 0;
`endif
    localparam int FRAME = PL + GN + NL;

    logic clk = 1'b0, reset = 1'b1, i_start = 1'b0, i_pre_end = 1'b0, i_pl_valid = 1'b0;
    logic [W-1:0] i_pre_data = '0, i_pl_data = '0;
    logic o_busy, o_done, o_pre_start, o_pl_ready, o_valid, o_underrun, o_pre_err;
    logic [W-1:0] o_data;

    vlc_frame_tx dut (
        .clk(clk), .reset(reset), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_pre_start(o_pre_start), .i_pre_data(i_pre_data), .i_pre_end(i_pre_end),
        .i_pl_data(i_pl_data), .i_pl_valid(i_pl_valid), .o_pl_ready(o_pl_ready),
        .o_data(o_data), .o_valid(o_valid), .o_underrun(o_underrun), .o_pre_err(o_pre_err)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int exp_q[$];
    int n_prestart = 0, n_done = 0, run = 0, last_run = 0, done_prev_valid = 0;
    int end_delay = 0;
    bit ur_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // preamble generator and payload source models
    initial begin
        int g = -1000, s = 0;
        bit prev_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (prev_ready) s++;
            if (o_pre_start) begin
                g = 0;
                s = 0;
            end else g++;
            i_pre_data = (g >= PD && g < PD + PL) ? W'(512 + g - PD) : '0;
            i_pre_end  = g == PL + 1 + end_delay;
            i_pl_valid = !(ur_en && s >= 5 && s <= 7);
            i_pl_data  = W'(s);
            prev_ready = o_pl_ready;
        end
    end

    initial begin
        int prev_valid = 0;
        forever begin
            @(negedge clk);
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sample: o_data=%0d with no expected sample queued", o_data);
                end else chk("sample", int'(o_data), exp_q.pop_front());
                run++;
            end else begin
                chk("idle_data", int'(o_data), 0);
                if (run > 0) last_run = run;
                run = 0;
            end
            if (o_pre_start) n_prestart++;
            if (o_done) begin
                n_done++;
                done_prev_valid = prev_valid;
            end
            prev_valid = int'(o_valid);
        end
    end

    task automatic push_frame(input bit ur);
        for (int k = 0; k < PL; k++) exp_q.push_back(512 + k);
        for (int k = 0; k < GN; k++) exp_q.push_back(0);
        for (int k = 0; k < NL; k++) exp_q.push_back((ur && k >= 5 && k <= 7) ? 0 : k);
    endtask

    task automatic wait_done;
        int c = 0;
        while (!o_done && c < 2000) begin
            step;
            c++;
        end
        if (!o_done) chk("done_timeout", int'(o_done), 1);
    endtask

    task automatic check_end(input int n0, input int frames);
        chk("done_after_last_valid", done_prev_valid, 1);
        chk("frame_len", last_run, FRAME);
        chk("queue_empty", exp_q.size(), 0);
        chk("pre_start_count", n_prestart - n0, frames);
    endtask

    task automatic run_frame(input bit ur, input int ed, input bit mid);
        int n0 = n_prestart;
        ur_en = ur;
        end_delay = ed;
        push_frame(ur);
        i_start = 1'b1;
        step;
        i_start = 1'b0;
        chk("pre_start_next_cycle", int'(o_pre_start), 1);
        chk("busy_next_cycle", int'(o_busy), 1);
        chk("underrun_cleared", int'(o_underrun), 0);
        chk("pre_err_cleared", int'(o_pre_err), 0);
        if (mid) begin
            repeat (50) step;
            i_start = 1'b1;
            step;
            i_start = 1'b0;
        end
        wait_done;
        chk("busy_low_at_done", int'(o_busy), 0);
        step;
        check_end(n0, 1);
    endtask

    initial begin
        int d, n0, nd, c;
        repeat (3) step;
        chk("rst_data", int'(o_data), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_pre_start", int'(o_pre_start), 0);
        chk("rst_ready", int'(o_pl_ready), 0);
        chk("rst_underrun", int'(o_underrun), 0);
        chk("rst_pre_err", int'(o_pre_err), 0);
        reset = 1'b0;
        repeat (7) step;
        run_frame(1'b0, 0, 1'b0);
        chk("clean_underrun", int'(o_underrun), 0);
        chk("clean_pre_err", int'(o_pre_err), 0);
        run_frame(1'b1, 0, 1'b0);
        repeat (5) step;
        chk("underrun_sticky", int'(o_underrun), 1);
        chk("underrun_no_pre_err", int'(o_pre_err), 0);
        run_frame(1'b0, 1, 1'b0);
        chk("late_end_pre_err", int'(o_pre_err), 1);
        run_frame(1'b0, 0, 1'b1);
        chk("mid_start_pre_err", int'(o_pre_err), 0);
        // back-to-back frames with i_start held high
        ur_en = 1'b0;
        end_delay = 0;
        n0 = n_prestart;
        push_frame(1'b0);
        push_frame(1'b0);
        i_start = 1'b1;
        step;
        wait_done;
        d = 0;
        do begin
            step;
            d++;
        end while (!o_pre_start && d < 10);
        chk("b2b_gap", d, 2);
        i_start = 1'b0;
        wait_done;
        step;
        check_end(n0, 2);
        // reset in the middle of the payload
        push_frame(1'b0);
        i_start = 1'b1;
        step;
        i_start = 1'b0;
        c = 0;
        while (!o_pl_ready && c < 1000) begin
            step;
            c++;
        end
        chk("reached_payload", int'(o_pl_ready), 1);
        repeat (10) step;
        nd = n_done;
        reset = 1'b1;
        step;
        chk("mid_rst_data", int'(o_data), 0);
        chk("mid_rst_valid", int'(o_valid), 0);
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_done", int'(o_done), 0);
        chk("mid_rst_ready", int'(o_pl_ready), 0);
        chk("mid_rst_pre_start", int'(o_pre_start), 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (5) step;
        chk("no_done_after_reset", n_done - nd, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
